// File: rtl/lsu_dm_master.sv
// Load/store unit turning byte/half/word core accesses into word-wide memory cycles.
// Optional macro LSU_RANGE_CHECK_EN rejects byte addresses with Addr[31:7] != 0.
module lsu_dm_master #(
  parameter int WORDS = 32
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        We,
  input  logic [1:0]  Size,
  input  logic        Sign,
  input  logic [31:0] Addr,
  input  logic [31:0] Wdata,
  output logic        Busy,
  output logic        Done,
  output logic        Err,
  output logic [31:0] Rdata,
  output logic [4:0]  Mem_A,
  output logic [31:0] Mem_D,
  output logic        Mem_we,
  output logic        Mem_re,
  input  logic [31:0] Mem_q
);
  localparam logic [4:0] LP_IDX_MASK = 5'(WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      r_state;
  logic        r_we, r_sign, r_err_lat, r_done, r_err;
  logic [1:0]  r_size, r_lane;
  logic [15:0] r_wdata;
  logic [31:0] r_rdata, r_mem_d;
  logic [4:0]  r_mem_a;
  logic        w_err, w_range_err;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load, w_merge;

`ifdef LSU_RANGE_CHECK_EN
  assign w_range_err = |Addr[31:7];
`else
  logic w_unused_hi;
  assign w_unused_hi = |Addr[31:7];
  assign w_range_err = 1'b0;
`endif

  // Reject sizes and alignments the memory cannot serve in one word cycle.
  always_comb begin
    w_err = 1'b0;
    case (Size)
      2'b00:   w_err = w_range_err;
      2'b01:   w_err = Addr[0] | w_range_err;
      2'b10:   w_err = (Addr[1:0] != 2'b00) | w_range_err;
      default: w_err = 1'b1;
    endcase
  end

  // Lane extraction for loads and lane merge for sub-word stores.
  always_comb begin
    w_byte  = Mem_q[{r_lane, 3'b000} +: 8];
    w_half  = r_lane[1] ? Mem_q[31:16] : Mem_q[15:0];
    w_load  = Mem_q;
    w_merge = Mem_q;
    case (r_size)
      2'b00: begin
        w_load = {{24{r_sign & w_byte[7]}}, w_byte};
        w_merge[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
      end
      2'b01: begin
        w_load = {{16{r_sign & w_half[15]}}, w_half};
        if (r_lane[1]) begin
          w_merge[31:16] = r_wdata;
        end else begin
          w_merge[15:0] = r_wdata;
        end
      end
      default: begin
        w_load  = Mem_q;
        w_merge = Mem_q;
      end
    endcase
  end

  // Access sequencer; DONE spends one cycle arming r_done and one presenting it.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state   <= S_IDLE;
      r_we      <= 1'b0;
      r_sign    <= 1'b0;
      r_size    <= 2'b00;
      r_lane    <= 2'b00;
      r_wdata   <= 16'h0000;
      r_err_lat <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_rdata   <= 32'h0000_0000;
      r_mem_a   <= 5'd0;
      r_mem_d   <= 32'h0000_0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Req) begin
            r_we      <= We;
            r_sign    <= Sign;
            r_size    <= Size;
            r_lane    <= Addr[1:0];
            r_wdata   <= Wdata[15:0];
            r_err_lat <= w_err;
            r_mem_a   <= Addr[6:2] & LP_IDX_MASK;
            if (w_err) begin
              r_state <= S_DONE;
            end else if (!We || (Size != 2'b10)) begin
              r_state <= S_RD;
            end else begin
              r_mem_d <= Wdata;
              r_state <= S_WR;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RD: r_state <= S_CAP;
        S_CAP: begin
          if (!r_we) begin
            r_rdata <= w_load;
            r_state <= S_DONE;
          end else begin
            r_mem_d <= w_merge;
            r_state <= S_WR;
          end
        end
        S_WR: r_state <= S_DONE;
        S_DONE: begin
          if (!r_done) begin
            r_done <= 1'b1;
            r_err  <= r_err_lat;
          end else begin
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Busy   = (r_state != S_IDLE);
  assign Mem_re = (r_state == S_RD);
  assign Mem_we = (r_state == S_WR);
  assign Done   = r_done;
  assign Err    = r_err;
  assign Rdata  = r_rdata;
  assign Mem_A  = r_mem_a;
  assign Mem_D  = r_mem_d;
endmodule

// File: tb/tb_lsu_dm_master.sv
// Self-checking bench for lsu_dm_master: directed plan steps then random accesses
// against a word-array reference model.
module tb_lsu_dm_master;
  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Req = 1'b0, We = 1'b0, Sign = 1'b0;
  logic [1:0]  Size = 2'b00;
  logic [31:0] Addr = 32'h0, Wdata = 32'h0;
  logic        Busy, Done, Err, Mem_we, Mem_re;
  logic [31:0] Rdata, Mem_D;
  logic [4:0]  Mem_A;
  logic [31:0] Mem_q;

  logic [31:0] mem [32];
  logic [31:0] ref_mem [32];
  logic        mem_init = 1'b1;
  int          re_cnt = 0, we_cnt = 0;
  int          n_cmp = 0, n_err = 0;
  logic [31:0] exp_rdata = 32'h0;

  lsu_dm_master #(.WORDS(32)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .We(We), .Size(Size), .Sign(Sign),
    .Addr(Addr), .Wdata(Wdata), .Busy(Busy), .Done(Done), .Err(Err),
    .Rdata(Rdata), .Mem_A(Mem_A), .Mem_D(Mem_D), .Mem_we(Mem_we),
    .Mem_re(Mem_re), .Mem_q(Mem_q)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] f_pat(input int i);
    return 32'h9E37_79B9 * 32'(i + 1);
  endfunction

  // Synchronous data memory: read data valid the cycle after Mem_re.
  always @(posedge Clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= f_pat(i);
    end else begin
      if (Mem_we) mem[Mem_A] <= Mem_D;
      if (Mem_re) Mem_q <= mem[Mem_A];
    end
    if (Mem_re) re_cnt <= re_cnt + 1;
    if (Mem_we) we_cnt <= we_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic f_err(input logic [1:0] size, input logic [31:0] addr);
    logic e;
    e = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
`ifdef LSU_RANGE_CHECK_EN
    if (addr >= 32'd128) e = 1'b1;
`endif
    return e;
  endfunction

  function automatic logic [31:0] f_load(input logic [31:0] word, input logic [1:0] size,
                                         input logic sign, input logic [31:0] addr);
    int unsigned sh;
    logic [31:0] v;
    if (size == 2'd0) begin
      sh = int'(addr[1:0]) * 8;
      v = (word >> sh) & 32'hFF;
      if (sign && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (size == 2'd1) begin
      sh = int'(addr[1]) * 16;
      v = (word >> sh) & 32'hFFFF;
      if (sign && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  function automatic logic [31:0] f_store(input logic [31:0] word, input logic [1:0] size,
                                          input logic [31:0] addr, input logic [31:0] wd);
    int unsigned sh;
    logic [31:0] m;
    if (size == 2'd0) begin
      sh = int'(addr[1:0]) * 8;
      m = 32'hFF << sh;
      return (word & ~m) | ((wd & 32'hFF) << sh);
    end else if (size == 2'd1) begin
      sh = int'(addr[1]) * 16;
      m = 32'hFFFF << sh;
      return (word & ~m) | ((wd & 32'hFFFF) << sh);
    end
    return wd;
  endfunction

  task automatic access(input logic we_i, input logic [1:0] size_i, input logic sign_i,
                        input logic [31:0] addr_i, input logic [31:0] wdata_i);
    int lat, exp_lat, re0, we0, exp_re, exp_we, idx;
    logic e, err_seen;
    e = f_err(size_i, addr_i);
    idx = int'(addr_i[6:2]);
    if (e) begin
      exp_lat = 1; exp_re = 0; exp_we = 0;
    end else if (!we_i) begin
      exp_lat = 3; exp_re = 1; exp_we = 0;
      exp_rdata = f_load(ref_mem[idx], size_i, sign_i, addr_i);
    end else if (size_i == 2'd2) begin
      exp_lat = 2; exp_re = 0; exp_we = 1;
      ref_mem[idx] = wdata_i;
    end else begin
      exp_lat = 4; exp_re = 1; exp_we = 1;
      ref_mem[idx] = f_store(ref_mem[idx], size_i, addr_i, wdata_i);
    end
    @(negedge Clk);
    Req = 1'b1; We = we_i; Size = size_i; Sign = sign_i; Addr = addr_i; Wdata = wdata_i;
    re0 = re_cnt; we0 = we_cnt;
    @(posedge Clk); #1;
    Req = 1'b0;
    chk("busy_rise", 32'(Busy), 32'd1);
    lat = 0; err_seen = 1'bx;
    for (int k = 1; k <= 8; k++) begin
      @(posedge Clk); #1;
      if (Done) begin lat = k; err_seen = Err; break; end
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("err", 32'(err_seen), 32'(e));
    chk("rdata", Rdata, exp_rdata);
    chk("re_count", 32'(re_cnt - re0), 32'(exp_re));
    chk("we_count", 32'(we_cnt - we0), 32'(exp_we));
    chk("mem_word", mem[idx], ref_mem[idx]);
    @(posedge Clk); #1;
    chk("done_fall", 32'({Done, Busy}), 32'd0);
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    for (int i = 0; i < 32; i++) ref_mem[i] = f_pat(i);
    repeat (3) @(posedge Clk);
    #1;
    chk("reset_ctl", 32'({Busy, Done, Err, Mem_we, Mem_re}), 32'd0);
    chk("reset_rdata", Rdata, 32'h0);
    chk("reset_mem_a", 32'(Mem_A), 32'h0);
    chk("reset_mem_d", Mem_D, 32'h0);
    @(negedge Clk);
    Reset = 1'b1; mem_init = 1'b0;

    access(1'b1, 2'd2, 1'b0, 32'h0C, 32'hDEAD_BEEF);
    chk("wst_mem_a", 32'(Mem_A), 32'd3);
    access(1'b0, 2'd2, 1'b0, 32'h0C, 32'h0);
    chk("wld_value", Rdata, 32'hDEAD_BEEF);
    access(1'b1, 2'd0, 1'b0, 32'h0D, 32'h55);
    chk("bst_mem_d", Mem_D, 32'hDEAD_55EF);
    access(1'b0, 2'd1, 1'b1, 32'h0E, 32'h0);
    chk("lh_signed", Rdata, 32'hFFFF_DEAD);
    access(1'b0, 2'd0, 1'b0, 32'h0F, 32'h0);
    chk("lbu", Rdata, 32'h0000_00DE);
    access(1'b0, 2'd0, 1'b1, 32'h0C, 32'h0);
    chk("lb_signed", Rdata, 32'hFFFF_FFEF);
    access(1'b0, 2'd1, 1'b0, 32'h0D, 32'h0);
    access(1'b1, 2'd2, 1'b0, 32'h0E, 32'h1234_5678);
    chk("misalign_rdata", Rdata, 32'hFFFF_FFEF);
    access(1'b0, 2'd2, 1'b0, 32'h80, 32'h0);

    // Req held high across a byte store; then reset lands in WR of the next one.
    @(negedge Clk);
    Req = 1'b1; We = 1'b1; Size = 2'd0; Sign = 1'b0; Addr = 32'h21; Wdata = 32'hA7;
    ref_mem[8] = f_store(ref_mem[8], 2'd0, 32'h21, 32'hA7);
    begin
      int re0, we0;
      re0 = re_cnt; we0 = we_cnt;
      @(posedge Clk); #1;
      Wdata = 32'h3C;
      repeat (4) begin @(posedge Clk); #1; end
      chk("held_done", 32'({Done, Busy}), 32'd3);
      @(posedge Clk); #1;
      chk("held_idle", 32'({Done, Busy}), 32'd0);
      chk("held_re", 32'(re_cnt - re0), 32'd1);
      chk("held_we", 32'(we_cnt - we0), 32'd1);
      chk("held_mem", mem[8], ref_mem[8]);
      @(posedge Clk); #1;
      chk("held_accept", 32'(Busy), 32'd1);
      Req = 1'b0;
      repeat (2) begin @(posedge Clk); #1; end
      chk("wr_state_we", 32'(Mem_we), 32'd1);
      #2 Reset = 1'b0;
      #1;
      chk("rst_async_ctl", 32'({Busy, Done, Err, Mem_we, Mem_re}), 32'd0);
      chk("rst_async_data", Rdata | Mem_D | 32'(Mem_A), 32'h0);
      @(posedge Clk);
      @(negedge Clk);
      Reset = 1'b1;
      exp_rdata = 32'h0;
      chk("rst_no_write", 32'(we_cnt - we0), 32'd1);
      chk("rst_mem", mem[8], ref_mem[8]);
    end

    for (int i = 0; i < 40; i++) begin
      sz = 2'($urandom_range(0, 3));
      a = 32'($urandom_range(0, 127));
      if ($urandom_range(0, 1) == 0) a = a & ~((32'd1 << sz) - 32'd1);
      if ($urandom_range(0, 7) == 0) a = a | ($urandom & 32'hFFFF_FF80);
      access(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
    end
    for (int i = 0; i < 32; i++) chk("final_mem", mem[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
